// File: rtl/shift_count.sv
// rtl/shift_count.sv - iterative CLZ/CTZ counter and normalizer, one binary-search step per cycle
module shift_count (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  count,
  output logic [31:0] norm
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic        op_r;
  logic [31:0] tmp;
  logic [5:0]  cnt;
  logic [2:0]  s;

  logic [5:0]  w;
  logic [31:0] hi_mask, lo_mask;
  logic        window_zero;
  logic [31:0] tmp_step;
  logic [5:0]  cnt_step;
  logic        zero_fix;
  logic [5:0]  cnt_next;

  // The window for step s is the top (CLZ) or bottom (CTZ) 16>>s bits of tmp.
  always_comb begin
    w       = 6'd16 >> s;
    hi_mask = 32'hFFFF0000;
    lo_mask = 32'h0000FFFF;
    case (s)
      3'd0:    begin hi_mask = 32'hFFFF0000; lo_mask = 32'h0000FFFF; end
      3'd1:    begin hi_mask = 32'hFF000000; lo_mask = 32'h000000FF; end
      3'd2:    begin hi_mask = 32'hF0000000; lo_mask = 32'h0000000F; end
      3'd3:    begin hi_mask = 32'hC0000000; lo_mask = 32'h00000003; end
      default: begin hi_mask = 32'h80000000; lo_mask = 32'h00000001; end
    endcase
    window_zero = op_r ? ((tmp & lo_mask) == 32'd0) : ((tmp & hi_mask) == 32'd0);
    tmp_step    = tmp;
    cnt_step    = cnt;
    if (window_zero) begin
      tmp_step = op_r ? (tmp >> w) : (tmp << w);
      cnt_step = cnt + w;
    end
    // After the last step a zero edge bit can only mean the operand was all zeros.
    zero_fix = (s == 3'd4) && (op_r ? !tmp_step[0] : !tmp_step[31]);
    cnt_next = cnt_step + {5'd0, zero_fix};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (s == 3'd4) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_r  <= 1'b0;
      tmp   <= 32'd0;
      cnt   <= 6'd0;
      s     <= 3'd0;
      count <= 6'd0;
      norm  <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r <= op;
            tmp  <= a;
            cnt  <= 6'd0;
            s    <= 3'd0;
          end
        end
        BUSY: begin
          tmp <= tmp_step;
          cnt <= cnt_next;
          s   <= s + 3'd1;
          if (s == 3'd4) begin
            count <= cnt_next;
            norm  <= tmp_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
